// File: rtl/tick_serial_tx_if.sv
// Word-transfer port of the tick-paced serial transmitter.
// Handshake: a word moves on a rising clk edge where valid=1 and ready=1.
// data_in only needs to be stable on that edge. valid may be raised at any time,
// and a producer may keep it high across back-to-back words.
interface tick_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;

  modport master (output data_in, output valid, input ready);
  modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/tick_serial_tx.sv
// Tick-paced serial transmitter.
// A word accepted on the bus is sent LSB-first as: start bit, DATA_W data bits,
// an optional parity bit, then STOP_BITS stop bits. The line advances one bit
// per cycle with tick=1 and holds its value while tick stays low.
// The state is exposed on state_dbg for observation.
module tick_serial_tx #(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active low
  input  logic             tick,
  tick_serial_tx_if.slave  bus,
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_dbg
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);
  localparam logic             PAR_ON    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]        stop_cnt_q, stop_cnt_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Register every piece of state; reset idles the line immediately and drops any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: only acceptance moves out of IDLE; all other moves wait for a tick.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (bus.valid && ready_q) begin
          shift_d  = bus.data_in;
          parity_d = (^bus.data_in) ^ PAR_ODD;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_ARMED;
        end
      end
      S_ARMED: begin
        // A tick on the acceptance edge was seen in IDLE, so it is not counted here.
        if (tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt_q < BIT_LAST) begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (PAR_ON) begin
            tx_d    = parity_q;
            state_d = S_PARITY;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = '0;
            state_d    = S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = '0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            tx_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.ready = ready_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_tick_serial_tx.sv
// Bench for tick_serial_tx. Three instances cover the default frame, even parity,
// and odd parity with two stop bits. Expected line values come from a frame list
// built from the word: start 0, data LSB-first, parity, then stop 1s.
module tb_tick_serial_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic tick;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int gap_lo   = 3;
  int gap_hi   = 3;

  logic [7:0] data_r [3];
  logic [2:0] valid_r;
  logic [2:0] ready_w, tx_w, busy_w, done_w;
  logic [2:0] st_a, st_b, st_c;

  tick_serial_tx_if #(.DATA_W(8)) if_a ();
  tick_serial_tx_if #(.DATA_W(8)) if_b ();
  tick_serial_tx_if #(.DATA_W(8)) if_c ();

  assign if_a.data_in = data_r[0];
  assign if_a.valid   = valid_r[0];
  assign ready_w[0]   = if_a.ready;
  assign if_b.data_in = data_r[1];
  assign if_b.valid   = valid_r[1];
  assign ready_w[1]   = if_b.ready;
  assign if_c.data_in = data_r[2];
  assign if_c.valid   = valid_r[2];
  assign ready_w[2]   = if_c.ready;

  tick_serial_tx #(.DATA_W(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .bus(if_a.slave),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]), .state_dbg(st_a));

  tick_serial_tx #(.DATA_W(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .bus(if_b.slave),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]), .state_dbg(st_b));

  tick_serial_tx #(.DATA_W(8), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
    .clk(clk), .rst(rst), .tick(tick), .bus(if_c.slave),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]), .state_dbg(st_c));

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Idle cycles without a tick; the line must not move.
  task automatic do_gap(input int idx, input logic prev);
    int g;
    g = $urandom_range(gap_hi, gap_lo);
    for (int k = 0; k < g; k++) begin
      cyc();
      chk("tx_hold", tx_w[idx], prev);
    end
  endtask

  task automatic accept(input int idx, input logic [7:0] w, input bit tick_too, input bit keep_valid);
    chk("pre_ready", ready_w[idx], 1'b1);
    data_r[idx]  = w;
    valid_r[idx] = 1'b1;
    tick         = tick_too;
    cyc();
    tick = 1'b0;
    if (!keep_valid) valid_r[idx] = 1'b0;
    chk("acc_ready", ready_w[idx], 1'b0);
    chk("acc_busy", busy_w[idx], 1'b1);
    chk("acc_tx", tx_w[idx], 1'b1);
  endtask

  // Tick out one whole frame and compare against the reference bit list.
  task automatic send_frame(input int idx, input logic [7:0] w, input bit pe, input bit po,
                            input int sb, input bit b2b, input int chg_at, input logic [7:0] chg_w);
    logic [0:0] exp_q [$];
    logic       prev;
    logic       e;
    int         n;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
    if (pe) exp_q.push_back((^w) ^ po);
    for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
    prev = 1'b1;
    n    = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (n == chg_at) data_r[idx] = chg_w;
      do_gap(idx, prev);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("tx_bit", tx_w[idx], e);
      chk("done_mid", done_w[idx], 1'b0);
      prev = e;
      n++;
    end
    do_gap(idx, prev);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("end_done", done_w[idx], 1'b1);
    chk("end_ready", ready_w[idx], 1'b1);
    chk("end_busy", busy_w[idx], 1'b0);
    chk("end_tx", tx_w[idx], 1'b1);
    if (!b2b) begin
      cyc();
      chk("done_pulse_end", done_w[idx], 1'b0);
    end
  endtask

  task automatic chk_reset_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_tx"}, tx_w[i], 1'b1);
      chk({tag, "_ready"}, ready_w[i], 1'b1);
      chk({tag, "_busy"}, busy_w[i], 1'b0);
      chk({tag, "_done"}, done_w[i], 1'b0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] w;
    bit         tt;
    rst       = 1'b0;
    tick      = 1'b0;
    valid_r   = '0;
    data_r[0] = '0;
    data_r[1] = '0;
    data_r[2] = '0;
    cyc();
    cyc();
    chk_reset_all("rst_init");
    chk("rst_state_a", {5'd0, st_a}, 8'd0);
    chk("rst_state_c", {5'd0, st_c}, 8'd0);
    rst = 1'b1;
    cyc();

    // Basic frame, tick every 4 cycles.
    gap_lo = 3; gap_hi = 3;
    accept(0, 8'hA5, 1'b0, 1'b0);
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b0, -1, 8'h00);

    // Parity: even on B, odd with two stop bits on C.
    accept(1, 8'h07, 1'b0, 1'b0);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1, 1'b0, -1, 8'h00);
    accept(2, 8'h07, 1'b0, 1'b0);
    send_frame(2, 8'h07, 1'b1, 1'b1, 2, 1'b0, -1, 8'h00);
    accept(2, 8'hFF, 1'b0, 1'b0);
    send_frame(2, 8'hFF, 1'b1, 1'b1, 2, 1'b0, -1, 8'h00);

    // Tick coincident with acceptance is not counted.
    accept(0, 8'h3C, 1'b1, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b0, -1, 8'h00);

    // Busy protection and back-to-back acceptance.
    accept(0, 8'h11, 1'b0, 1'b1);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1, 1'b1, 4, 8'hEE);
    cyc();
    valid_r[0] = 1'b0;
    chk("b2b_ready", ready_w[0], 1'b0);
    chk("b2b_busy", busy_w[0], 1'b1);
    chk("b2b_done", done_w[0], 1'b0);
    send_frame(0, 8'hEE, 1'b0, 1'b0, 1, 1'b0, -1, 8'h00);

    // Reset while idle, asserted between clock edges.
    #2;
    rst = 1'b0;
    #1;
    chk_reset_all("rst_idle");
    cyc();
    rst = 1'b1;
    cyc();

    // Reset mid-frame while the start bit is on the line.
    accept(0, 8'hA5, 1'b0, 1'b0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("pre_rst_tx", tx_w[0], 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_tx", tx_w[0], 1'b1);
    chk("rst_mid_ready", ready_w[0], 1'b1);
    chk("rst_mid_busy", busy_w[0], 1'b0);
    chk("rst_mid_done", done_w[0], 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("post_rst_ready", ready_w[0], 1'b1);
    chk("post_rst_tx", tx_w[0], 1'b1);

    // Random words, random tick spacing, random coincident ticks.
    gap_lo = 0; gap_hi = 3;
    for (int n = 0; n < 12; n++) begin
      w  = 8'($urandom_range(0, 255));
      tt = 1'($urandom_range(0, 1));
      accept(0, w, tt, 1'b0);
      send_frame(0, w, 1'b0, 1'b0, 1, 1'b0, -1, 8'h00);
    end
    for (int n = 0; n < 4; n++) begin
      w  = 8'($urandom_range(0, 255));
      tt = 1'($urandom_range(0, 1));
      accept(1, w, tt, 1'b0);
      send_frame(1, w, 1'b1, 1'b0, 1, 1'b0, -1, 8'h00);
      w  = 8'($urandom_range(0, 255));
      accept(2, w, 1'b0, 1'b0);
      send_frame(2, w, 1'b1, 1'b1, 2, 1'b0, -1, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
